// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - critical-word-first WRAP4 refill sequencer for the AHB-Lite icache
module icache_refill_ctrl #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              hclk,
  input  logic              hrst,
  input  logic              miss_req,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              miss_ready,
  output logic              crit_valid,
  output logic [31:0]       crit_data,
  output logic              fill_valid,
  output logic              fill_err,
  output logic [LINE_W-1:0] fill_line,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic [2:0]        hburst,
  output logic [2:0]        hsize,
  output logic              hwrite,
  input  logic              hready,
  input  logic [31:0]       hrdata,
  input  logic              hresp
);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_ABORT, S_DONE} state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  state_e              state_q;
  logic [2:0]          a_cnt_q, d_cnt_q;
  logic [1:0]          crit_q;
  logic [1:0]          htrans_q;
  logic [ADDR_W-1:0]   haddr_q;
  logic [ADDR_W-1:0]   fill_addr_q;
  logic [LINE_W-1:0]   fill_line_q;
  logic [31:0]         crit_data_q;
  logic                crit_valid_q, fill_valid_q, fill_err_q;

  logic                addr_acc, data_acc;
  logic [2:0]          a_cnt_d, d_cnt_d;
  logic [1:0]          beat_d, word_idx;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^miss_addr[1:0];

  always_comb begin
    addr_acc = hready && (htrans_q != HTRANS_IDLE);
    // a data phase is pending whenever more addresses than data beats were accepted
    data_acc = hready && (a_cnt_q != d_cnt_q);
    a_cnt_d  = a_cnt_q + 3'd1;
    d_cnt_d  = d_cnt_q + 3'd1;
    beat_d   = crit_q + a_cnt_d[1:0];
    word_idx = crit_q + d_cnt_q[1:0];
  end

  always_ff @(posedge hclk) begin
    if (hrst) begin
      state_q      <= S_IDLE;
      a_cnt_q      <= 3'd0;
      d_cnt_q      <= 3'd0;
      crit_q       <= 2'd0;
      htrans_q     <= HTRANS_IDLE;
      haddr_q      <= '0;
      fill_addr_q  <= '0;
      fill_line_q  <= '0;
      crit_data_q  <= 32'd0;
      crit_valid_q <= 1'b0;
      fill_valid_q <= 1'b0;
      fill_err_q   <= 1'b0;
    end else begin
      crit_valid_q <= 1'b0;
      fill_valid_q <= 1'b0;
      fill_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (miss_req) begin
            fill_addr_q <= {miss_addr[ADDR_W-1:4], 4'b0000};
            crit_q      <= miss_addr[3:2];
            a_cnt_q     <= 3'd0;
            d_cnt_q     <= 3'd0;
            htrans_q    <= HTRANS_NONSEQ;
            haddr_q     <= {miss_addr[ADDR_W-1:4], miss_addr[3:2], 2'b00};
            state_q     <= S_BURST;
          end
        end
        S_BURST: begin
          if (hresp && !hready) begin
            htrans_q <= HTRANS_IDLE;
            state_q  <= S_ABORT;
          end else if (hresp) begin
            htrans_q   <= HTRANS_IDLE;
            fill_err_q <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            if (addr_acc) begin
              a_cnt_q <= a_cnt_d;
              if (a_cnt_d == 3'd4) begin
                htrans_q <= HTRANS_IDLE;
              end else begin
                htrans_q <= HTRANS_SEQ;
                haddr_q  <= {fill_addr_q[ADDR_W-1:4], beat_d, 2'b00};
              end
            end
            if (data_acc) begin
              fill_line_q[{word_idx, 5'b00000} +: 32] <= hrdata;
              d_cnt_q <= d_cnt_d;
              if (d_cnt_q == 3'd0) begin
                crit_data_q  <= hrdata;
                crit_valid_q <= 1'b1;
              end
              if (d_cnt_q == 3'd3) begin
                fill_valid_q <= 1'b1;
                state_q      <= S_DONE;
              end
            end
          end
        end
        S_ABORT: begin
          // second cycle of the two-cycle ERROR response
          if (hready) begin
            fill_err_q <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign miss_ready = (state_q == S_IDLE);
  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;
  assign fill_valid = fill_valid_q;
  assign fill_err   = fill_err_q;
  assign fill_line  = fill_line_q;
  assign fill_addr  = fill_addr_q;
  assign haddr      = haddr_q;
  assign htrans     = htrans_q;
  assign hburst     = 3'b010;
  assign hsize      = 3'b010;
  assign hwrite     = 1'b0;

endmodule
